n4_rr_collect_10_1: RTL and testbench
=====================================

# n4_rr_collect_10_1

Ten-lane round-robin collector: the sequential counterpart of the 1-to-10 demultiplexer on the N4 datapath. Takes up to ten independent valid/ready input lanes, grants one lane per cycle under a fair rotating priority, and registers the winning word with its lane index. The result is a single valid/ready stream whose 8-bit `out_select` code (0–9) drives the downstream 1-to-10 demultiplexer's `select` directly. A transfer counter supports throughput checks.

## Interface
- `WIDTH`, 16, data width of every lane and of the output.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `ch_en`  input  10  per-lane enable; a lane with `ch_en[i]=0` is never granted.
- `in_valid`  input  10  per-lane data valid.
- `in_data`  input  10*WIDTH  lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_ready`  output  10  per-lane accept; at most one bit high in any cycle.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  downstream accept.
- `out_data`  output  WIDTH  collected word.
- `out_select`  output  8  lane index of `out_data`, 8'd0–8'd9.
- `xfer_cnt`  output  16  number of completed output handshakes; wraps 16'hFFFF→0.

## Operation
- State: rotating pointer `ptr` (0–9), output register (`out_valid`, `out_data`, `out_select`), `xfer_cnt`.
- Eligible lane i: `in_valid[i] & ch_en[i]`.
- Grant: first eligible lane searching `ptr, ptr+1, …, 9, 0, …, ptr-1`. No eligible lane means no grant.
- `can_load = !out_valid | out_ready`.
- `in_ready[i] = can_load & (grant == i)`. Combinational from `in_valid`, `ch_en`, `ptr`, `out_valid`, `out_ready`.
- Accept (grant exists and `can_load`):
  - load `out_data` ← lane word;
  - load `out_select` ← grant index;
  - set `out_valid` ← 1;
  - set `ptr` ← grant+1, with 9 wrapping to 0.
- Output handshake (`out_valid & out_ready`):
  - increment `xfer_cnt`;
  - if no accept in the same cycle, clear `out_valid`.
  - `out_data`/`out_select` hold their last values while `out_valid=0`.
- Simultaneous drain and accept: the new word replaces the old word in the same edge and `out_valid` stays 1. Sustained throughput is one word per cycle.
- Stall (`out_valid & !out_ready`):
  - all `in_ready` are 0;
  - output register, `ptr` and `xfer_cnt` hold.
- `ptr` advances only on an accept, never on idle cycles.
- `ch_en` changes take effect in the same cycle. Disabling the lane whose word is already in the output register does not remove that word.
- Reset (asynchronous assert, any time, including mid-stall):
  - `out_valid=0`, `out_data=0`, `out_select=8'd0`, `ptr=0`, `xfer_cnt=0`;
  - `in_ready=0` while `rst_n=0`;
  - a word in flight is discarded.
- `out_select` never takes values above 8'd9.

## Timing
- Latency: a word accepted at edge N is visible on `out_data`/`out_select` with `out_valid=1` after edge N, i.e. one cycle.
- Input handshake completes on the edge where `in_valid[i] & in_ready[i]`. Output handshake completes on the edge where `out_valid & out_ready`.
- Fairness: with all ten lanes continuously eligible and `out_ready=1`, grants go 0,1,…,9,0,… and each lane is served exactly once per 10 cycles.
- Worst-case wait for an eligible lane with `out_ready=1`: 9 accepts.
- Reset release: first accept possible on the first rising edge after `rst_n` deasserts.
- No combinational path from `out_ready` to `out_valid`. The path from `out_ready` to `in_ready` is combinational by design.

## Test plan
- Reset, then idle: `in_valid=0`, `ch_en=10'h3FF`, 5 cycles → `out_valid=0`, `in_ready=0`, `out_select=0`, `xfer_cnt=0`.
- Full-load rotation: all lanes valid, lane i data=16'h0100+i, `out_ready=1`, 20 cycles → `out_select` sequence 0..9,0..9; data 16'h0100..16'h0109 repeated; `xfer_cnt=20` one cycle after the last accept.
- Pointer fairness: after a grant to lane 3, only lanes 1 and 7 valid → lane 7 granted first, then lane 1 (`out_select` 7 then 1).
- Backpressure: lanes 2 and 5 valid, `out_ready=0` for 4 cycles after the first load → `out_select=2` held, `in_ready=0`, `xfer_cnt` unchanged. Then `out_ready=1` → lane 5 loads on the same edge that lane 2 drains.
- Enable mask: `ch_en=10'b0000010000`, all lanes valid → only lane 4 is ever granted, one word per cycle. Set `ch_en=0` → no grants and `out_valid` clears after the final drain.
- Reset mid-operation: assert `rst_n=0` asynchronously while `out_valid=1` and `out_ready=0` → `out_valid`, `out_data`, `xfer_cnt` go 0 without a clock edge. After release, with all lanes valid, the next grant is lane 0.

Source files
------------

// File: rtl/n4_rr_collect_10_1.sv
// n4_rr_collect_10_1: ten-lane round-robin collector feeding the N4 1-to-10 demux.
// One lane is granted per cycle under a rotating priority, and the winning word is
// registered together with its lane index.

// Per-lane qualifier: eligibility and the accept strobe back to the lane.
module n4_rr_lane (
  input  logic rst_n,
  input  logic valid_i,
  input  logic en_i,
  input  logic hit_i,
  input  logic can_load_i,
  output logic elig_o,
  output logic ready_o
);
  assign elig_o  = valid_i & en_i;
  // Held low during reset, even though the registers already read as empty.
  assign ready_o = rst_n & can_load_i & hit_i;
endmodule

module n4_rr_collect_10_1 #(
  parameter int WIDTH     = 16,
  parameter int NUM_LANES = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES-1:0]       ch_en_i,
  input  logic [NUM_LANES-1:0]       in_valid_i,
  input  logic [NUM_LANES*WIDTH-1:0] in_data_i,
  output logic [NUM_LANES-1:0]       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [7:0]                 out_select_o,
  output logic [15:0]                xfer_cnt_o
);
  logic [3:0]           ptr_q, ptr_d;
  logic                 ov_q, ov_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [3:0]           sel_q, sel_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [NUM_LANES-1:0] elig, gnt_oh;
  logic [15:0]          elig_pad;
  logic                 gnt_vld, can_load, accept, drain;
  logic [3:0]           gnt_idx;
  logic [4:0]           cand;
  logic [WIDTH-1:0]     lane_word;

  assign can_load = !ov_q | out_ready_i;
  assign accept   = gnt_vld & can_load;
  assign drain    = ov_q & out_ready_i;
  assign elig_pad = {{(16-NUM_LANES){1'b0}}, elig};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign gnt_oh[i] = gnt_vld & (gnt_idx == 4'(i));
    n4_rr_lane u_lane (
      .rst_n      (rst_n),
      .valid_i    (in_valid_i[i]),
      .en_i       (ch_en_i[i]),
      .hit_i      (gnt_oh[i]),
      .can_load_i (can_load),
      .elig_o     (elig[i]),
      .ready_o    (in_ready_o[i])
    );
  end

  // Rotating search: first eligible lane starting at ptr, wrapping past the last lane.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 4'd0;
    cand    = 5'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, ptr_q} + 5'(k);
      if (cand >= 5'(NUM_LANES)) cand = cand - 5'(NUM_LANES);
      if (!gnt_vld && elig_pad[cand[3:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[3:0];
      end
    end
  end

  // Select the granted lane's word.
  always_comb begin
    lane_word = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (gnt_idx == 4'(i)) lane_word = in_data_i[i*WIDTH +: WIDTH];
  end

  // Next state: a load wins over a drain, so drain+accept keeps the register full.
  always_comb begin
    ptr_d  = ptr_q;
    ov_d   = ov_q;
    data_d = data_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    if (drain) begin
      cnt_d = cnt_q + 16'd1;
      ov_d  = 1'b0;
    end
    if (accept) begin
      ov_d   = 1'b1;
      data_d = lane_word;
      sel_d  = gnt_idx;
      ptr_d  = (gnt_idx == 4'(NUM_LANES-1)) ? 4'd0 : gnt_idx + 4'd1;
    end
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      ov_q   <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      ov_q   <= ov_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid_o  = ov_q;
  assign out_data_o   = data_q;
  assign out_select_o = {4'd0, sel_q};
  assign xfer_cnt_o   = cnt_q;
endmodule

// File: tb/tb_n4_rr_collect_10_1.sv
// Directed, table-driven bench for n4_rr_collect_10_1.
module tb_n4_rr_collect_10_1;
  localparam int W = 16;

  typedef struct {
    logic [9:0]  ch;
    logic [9:0]  v;
    logic        rdy;
    logic [9:0]  e_inr;
    logic        e_ov;
    logic [7:0]  e_sel;
    logic [15:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    ch_en = 10'h3FF, in_valid = '0, in_ready;
  logic [10*W-1:0] in_data;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [7:0]    out_select;
  logic [15:0]   xfer_cnt;

  int checks = 0, failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  n4_rr_collect_10_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en_i(ch_en), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_select_o(out_select),
    .xfer_cnt_o(xfer_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [9:0] ch, input logic [9:0] v, input logic rdy,
                     input logic [9:0] inr, input logic ov, input logic [7:0] sel,
                     input logic [15:0] data, input logic [15:0] cnt);
    vec_t r;
    r.ch = ch; r.v = v; r.rdy = rdy; r.e_inr = inr;
    r.e_ov = ov; r.e_sel = sel; r.e_data = data; r.e_cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic chk_regs(input string tag, input vec_t r);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(r.e_ov));
    chk({tag, ".out_select"}, 32'(out_select), 32'(r.e_sel));
    chk({tag, ".out_data"}, 32'(out_data), 32'(r.e_data));
    chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(r.e_cnt));
  endtask

  // Drive inputs, check the combinational ready, clock once, check registers.
  task automatic step(input string tag, input vec_t r);
    ch_en = r.ch; in_valid = r.v; out_ready = r.rdy;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'(r.e_inr));
    @(posedge clk);
    #1 chk_regs(tag, r);
  endtask

  initial begin
    vec_t r;
    for (int i = 0; i < 10; i++) in_data[i*W +: W] = 16'h0100 + 16'(i);

    // Idle after reset
    for (int k = 0; k < 5; k++) add(10'h3FF, 10'h000, 1'b1, 10'h000, 0, 8'd0, 16'h0000, 16'd0);
    // Full-load rotation: one grant per cycle, 0..9 twice
    for (int k = 0; k < 20; k++)
      add(10'h3FF, 10'h3FF, 1'b1, 10'(1 << (k % 10)), 1, 8'(k % 10), 16'h0100 + 16'(k % 10), 16'(k));
    add(10'h3FF, 10'h000, 1'b1, 10'h000, 0, 8'd9, 16'h0109, 16'd20);
    // Pointer fairness: grant 3, then lanes 1 and 7 -> 7 first, then 1
    add(10'h3FF, 10'h008, 1'b1, 10'h008, 1, 8'd3, 16'h0103, 16'd20);
    add(10'h3FF, 10'h082, 1'b1, 10'h080, 1, 8'd7, 16'h0107, 16'd21);
    add(10'h3FF, 10'h082, 1'b1, 10'h002, 1, 8'd1, 16'h0101, 16'd22);
    add(10'h3FF, 10'h000, 1'b1, 10'h000, 0, 8'd1, 16'h0101, 16'd23);
    // Backpressure: lane 2 loads, stalls 4 cycles, lane 5 loads as lane 2 drains
    add(10'h3FF, 10'h024, 1'b0, 10'h004, 1, 8'd2, 16'h0102, 16'd23);
    for (int k = 0; k < 4; k++) add(10'h3FF, 10'h024, 1'b0, 10'h000, 1, 8'd2, 16'h0102, 16'd23);
    add(10'h3FF, 10'h024, 1'b1, 10'h020, 1, 8'd5, 16'h0105, 16'd24);
    add(10'h3FF, 10'h000, 1'b1, 10'h000, 0, 8'd5, 16'h0105, 16'd25);
    // Enable mask: only lane 4, then nothing
    add(10'h010, 10'h3FF, 1'b1, 10'h010, 1, 8'd4, 16'h0104, 16'd25);
    add(10'h010, 10'h3FF, 1'b1, 10'h010, 1, 8'd4, 16'h0104, 16'd26);
    add(10'h010, 10'h3FF, 1'b1, 10'h010, 1, 8'd4, 16'h0104, 16'd27);
    add(10'h000, 10'h3FF, 1'b1, 10'h000, 0, 8'd4, 16'h0104, 16'd28);
    add(10'h000, 10'h3FF, 1'b1, 10'h000, 0, 8'd4, 16'h0104, 16'd28);

    // Reset state, with every lane requesting
    in_valid = 10'h3FF; out_ready = 1'b1;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    r.e_ov = 0; r.e_sel = 0; r.e_data = 0; r.e_cnt = 0;
    chk_regs("rst", r);
    in_valid = '0;
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Mid-stall asynchronous reset: ptr is 5, so lane 5 loads and stalls
    add(10'h3FF, 10'h3FF, 1'b0, 10'h020, 1, 8'd5, 16'h0105, 16'd28);
    step("midrst.load", tbl[tbl.size()-1]);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    r.e_ov = 0; r.e_sel = 0; r.e_data = 0; r.e_cnt = 0;
    chk_regs("midrst", r);
    @(negedge clk) rst_n = 1'b1;
    // Pointer back at 0 after release
    add(10'h3FF, 10'h3FF, 1'b1, 10'h001, 1, 8'd0, 16'h0100, 16'd0);
    step("postrst", tbl[tbl.size()-1]);
    add(10'h3FF, 10'h3FF, 1'b1, 10'h002, 1, 8'd1, 16'h0101, 16'd1);
    step("postrst2", tbl[tbl.size()-1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, limit 20000 reached");
    $fatal(1, "timeout");
  end
endmodule
